// File: rtl/reaction_stimulus_if.sv
// Signal bundle between the reaction-timer front end and its environment.
// There is no valid/ready handshake on this bundle: Startn and Pushn_raw are
// raw level inputs, c9 and w are single-cycle pulses, and Pushn, Busy and
// dbg_state are levels that are valid in every cycle.
interface reaction_stimulus_if;
    logic       Startn;
    logic       Pushn_raw;
    logic       c9;
    logic       w;
    logic       Pushn;
    logic       Busy;
    logic [1:0] dbg_state;

    modport master (output Startn, Pushn_raw, input c9, w, Pushn, Busy, dbg_state);
    modport slave  (input Startn, Pushn_raw, output c9, w, Pushn, Busy, dbg_state);
endinterface

// File: rtl/reaction_stimulus.sv
// Reaction-timer front end: 100 Hz tick prescaler, free-running LFSR,
// button synchronisers/debouncers and the trial-sequencing FSM that issues
// a randomly delayed start pulse w.
module reaction_stimulus #(
    parameter int DIV        = 500000,
    parameter int MIN_DELAY  = 100,
    parameter int RANGE_BITS = 8,
    parameter int DEB_TICKS  = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    reaction_stimulus_if.slave  bus
);
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(DEB_TICKS + 1);
    localparam int DW_NEED = $clog2(MIN_DELAY + (1 << RANGE_BITS)) + 1;
    localparam int DW      = (DW_NEED > RANGE_BITS + 8) ? DW_NEED : RANGE_BITS + 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FIRE  = 2'd2,
        ARMED = 2'd3
    } state_t;

    // Index 0 is the start button, index 1 the response button.
    logic [PW-1:0]        presc_q, presc_d;
    logic                 c9;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [1:0]           sync1_q, sync1_d;
    logic [1:0]           sync2_q, sync2_d;
    logic [1:0]           db_q, db_d;
    logic [1:0][CW-1:0]   run_q, run_d;
    state_t               state_q, state_d;
    logic [DW-1:0]        delay_q, delay_d;
    logic                 w_q, w_d;
    logic                 busy_q, busy_d;
    logic                 press;

    // Prescaler wraps at DIV-1; the tick is the decode of that terminal count.
    always_comb begin
        c9      = (presc_q == PW'(DIV - 1));
        presc_d = c9 ? '0 : presc_q + 1'b1;
    end

    // LFSR (taps 16,14,13,11) and the two-flop button synchronisers.
    always_comb begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sync1_d = {bus.Pushn_raw, bus.Startn};
        sync2_d = sync1_q;
    end

    // Debounce: count consecutive tick samples that differ from the output.
    always_comb begin
        db_d  = db_q;
        run_d = run_q;
        for (int i = 0; i < 2; i++) begin
            if (c9) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (run_q[i] == CW'(DEB_TICKS - 1)) begin
                        db_d[i]  = sync2_q[i];
                        run_d[i] = '0;
                    end else begin
                        run_d[i] = run_q[i] + 1'b1;
                    end
                end else begin
                    run_d[i] = '0;
                end
            end
        end
        press = db_q[0] & ~db_d[0];
    end

    // Trial sequencer: a pending early press (cheat) overrides the final tick.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    delay_d = DW'(MIN_DELAY) + DW'(lfsr_q[RANGE_BITS-1:0]);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!db_q[1]) begin
                    state_d = IDLE;
                end else if (c9) begin
                    delay_d = delay_q - 1'b1;
                    if (delay_q == DW'(1)) begin
                        state_d = FIRE;
                    end
                end
            end
            FIRE: begin
                state_d = ARMED;
            end
            ARMED: begin
                if (!db_q[1]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        w_d    = (state_d == FIRE);
        busy_d = (state_d != IDLE);
    end

    // State register for all of the above, with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            presc_q <= '0;
            lfsr_q  <= LFSR_SEED;
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            run_q   <= '0;
            state_q <= IDLE;
            delay_q <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            lfsr_q  <= lfsr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            run_q   <= run_d;
            state_q <= state_d;
            delay_q <= delay_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.c9        = c9;
    assign bus.w         = w_q;
    assign bus.Pushn     = db_q[1];
    assign bus.Busy      = busy_q;
    assign bus.dbg_state = state_q;
endmodule
